// File: rtl/rf_pkg.sv
// Shared types, constants and the write-port arbitration helper for the tagged register file.
package rf_pkg;

    localparam int unsigned RF_DATA_BITS = 32;
    localparam int unsigned RF_ADDR_BITS = 5;
    localparam int unsigned RF_TAG_BITS  = 6;
    localparam int unsigned RF_ZERO_ADDR = 0;

    // Upper bound on writeback ports the arbitration helper can select among.
    localparam int unsigned MAX_WR_PORTS = 16;

    typedef logic [RF_ADDR_BITS-1:0] rf_addr_t;
    typedef logic [RF_DATA_BITS-1:0] rf_data_t;
    typedef logic [RF_TAG_BITS-1:0]  rf_tag_t;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic int unsigned onehot_hi_index(input logic [MAX_WR_PORTS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_WR_PORTS; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_wb_match.sv
// Finds the effective writeback (if any) that targets one register address this cycle.
module rf_wb_match
    import rf_pkg::*;
#(
    parameter int unsigned RF_WIDTH     = 32,
    parameter int unsigned RF_DEPTH     = 32,
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter int unsigned TAG_WIDTH    = 6,
    parameter int unsigned AW           = $clog2(RF_DEPTH),
    parameter int unsigned PW           = (NUM_WR_PORTS > 1) ? $clog2(NUM_WR_PORTS) : 1
) (
    input  logic [AW-1:0]                     addr,
    input  logic [RF_DEPTH-1:0]               busy,
    input  logic [RF_DEPTH*TAG_WIDTH-1:0]     tags,
    input  logic [NUM_WR_PORTS-1:0]           wb_en,
    input  logic [NUM_WR_PORTS*AW-1:0]        wb_addr,
    input  logic [NUM_WR_PORTS*TAG_WIDTH-1:0] wb_tag,
    input  logic [NUM_WR_PORTS*RF_WIDTH-1:0]  wb_data,
    output logic                              hit,
    output logic [RF_WIDTH-1:0]               hit_data,
    output logic [PW-1:0]                     hit_port
);

    logic [NUM_WR_PORTS-1:0] match;
    logic [MAX_WR_PORTS-1:0] match_ext;
    logic [AW-1:0]           wa;
    int unsigned             idx;

    always_comb begin
        match     = '0;
        match_ext = '0;
        wa        = '0;
        for (int unsigned j = 0; j < NUM_WR_PORTS; j++) begin
            wa = wb_addr[j*AW +: AW];
            // Only results whose tag still names the current producer are accepted.
            match[j] = wb_en[j] && (wa != AW'(RF_ZERO_ADDR)) && (wa == addr) && busy[wa] &&
                       (tags[wa*TAG_WIDTH +: TAG_WIDTH] == wb_tag[j*TAG_WIDTH +: TAG_WIDTH]);
        end
        match_ext[NUM_WR_PORTS-1:0] = match;
        idx      = onehot_hi_index(match_ext);
        hit      = |match;
        hit_port = PW'(idx);
        hit_data = hit ? wb_data[idx*RF_WIDTH +: RF_WIDTH] : '0;
    end

endmodule

// File: rtl/rf_tagged_mp.sv
// Multi-ported register file with hardwired zero register, write-to-read bypass and busy/tag status.
module rf_tagged_mp
    import rf_pkg::*;
#(
    parameter int unsigned RF_WIDTH     = 32,
    parameter int unsigned RF_DEPTH     = 32,
    parameter int unsigned NUM_RD_PORTS = 4,
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter int unsigned TAG_WIDTH    = 6,
    parameter int unsigned AW           = $clog2(RF_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD_PORTS*AW-1:0]        rs_addr,
    output logic [NUM_RD_PORTS*RF_WIDTH-1:0]  rs_data_out,
    output logic [NUM_RD_PORTS-1:0]           rs_busy,
    output logic [NUM_RD_PORTS*TAG_WIDTH-1:0] rs_tag,
    input  logic                              alloc_en,
    input  logic [AW-1:0]                     alloc_addr,
    input  logic [TAG_WIDTH-1:0]              alloc_tag,
    input  logic [NUM_WR_PORTS-1:0]           wb_en,
    input  logic [NUM_WR_PORTS*AW-1:0]        wb_addr,
    input  logic [NUM_WR_PORTS*TAG_WIDTH-1:0] wb_tag,
    input  logic [NUM_WR_PORTS*RF_WIDTH-1:0]  wb_data,
    input  logic                              flush
);

    localparam int unsigned PW = (NUM_WR_PORTS > 1) ? $clog2(NUM_WR_PORTS) : 1;

    logic [RF_WIDTH-1:0]           data_q [RF_DEPTH];
    logic [RF_WIDTH-1:0]           data_d [RF_DEPTH];
    logic [RF_DEPTH-1:0]           busy_q, busy_d;
    logic [RF_DEPTH*TAG_WIDTH-1:0] tag_q, tag_d;

    logic [RF_DEPTH-1:0]     reg_hit;
    logic [RF_WIDTH-1:0]     reg_hit_data [RF_DEPTH];
    logic [PW-1:0]           unused_reg_port [RF_DEPTH];

    logic [NUM_RD_PORTS-1:0] rd_hit;
    logic [RF_WIDTH-1:0]     rd_hit_data [NUM_RD_PORTS];
    logic [PW-1:0]           unused_rd_port [NUM_RD_PORTS];

    // Per-register effective-write detection for the state update.
    for (genvar r = 0; r < RF_DEPTH; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign reg_hit[r]         = 1'b0;
            assign reg_hit_data[r]    = '0;
            assign unused_reg_port[r] = '0;
        end else begin : g_match
            rf_wb_match #(
                .RF_WIDTH     (RF_WIDTH),
                .RF_DEPTH     (RF_DEPTH),
                .NUM_WR_PORTS (NUM_WR_PORTS),
                .TAG_WIDTH    (TAG_WIDTH),
                .AW           (AW),
                .PW           (PW)
            ) u_match (
                .addr     (AW'(r)),
                .busy     (busy_q),
                .tags     (tag_q),
                .wb_en    (wb_en),
                .wb_addr  (wb_addr),
                .wb_tag   (wb_tag),
                .wb_data  (wb_data),
                .hit      (reg_hit[r]),
                .hit_data (reg_hit_data[r]),
                .hit_port (unused_reg_port[r])
            );
        end
    end

    // Per-read-port bypass detection.
    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
        rf_wb_match #(
            .RF_WIDTH     (RF_WIDTH),
            .RF_DEPTH     (RF_DEPTH),
            .NUM_WR_PORTS (NUM_WR_PORTS),
            .TAG_WIDTH    (TAG_WIDTH),
            .AW           (AW),
            .PW           (PW)
        ) u_match (
            .addr     (rs_addr[i*AW +: AW]),
            .busy     (busy_q),
            .tags     (tag_q),
            .wb_en    (wb_en),
            .wb_addr  (wb_addr),
            .wb_tag   (wb_tag),
            .wb_data  (wb_data),
            .hit      (rd_hit[i]),
            .hit_data (rd_hit_data[i]),
            .hit_port (unused_rd_port[i])
        );
    end

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int unsigned r = 0; r < RF_DEPTH; r++) begin
            data_d[r] = data_q[r];
            if (reg_hit[r]) begin
                data_d[r] = reg_hit_data[r];
                busy_d[r] = 1'b0;
            end
        end
        // Alloc takes status priority over a same-cycle writeback; flush beats both.
        if (alloc_en && !flush && (alloc_addr != AW'(RF_ZERO_ADDR))) begin
            busy_d[alloc_addr]                         = 1'b1;
            tag_d[alloc_addr*TAG_WIDTH +: TAG_WIDTH]   = alloc_tag;
        end
        if (flush) busy_d = '0;
        data_d[0]               = '0;
        busy_d[0]               = 1'b0;
        tag_d[0 +: TAG_WIDTH]   = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < RF_DEPTH; r++) data_q[r] <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            for (int unsigned r = 0; r < RF_DEPTH; r++) data_q[r] <= data_d[r];
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    logic [AW-1:0] ra;

    always_comb begin
        ra = '0;
        for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
            ra = rs_addr[i*AW +: AW];
            if (ra == AW'(RF_ZERO_ADDR)) begin
                rs_data_out[i*RF_WIDTH +: RF_WIDTH]  = '0;
                rs_busy[i]                           = 1'b0;
                rs_tag[i*TAG_WIDTH +: TAG_WIDTH]     = '0;
            end else begin
                rs_data_out[i*RF_WIDTH +: RF_WIDTH]  = rd_hit[i] ? rd_hit_data[i] : data_q[ra];
                rs_busy[i]                           = rd_hit[i] ? 1'b0 : busy_q[ra];
                rs_tag[i*TAG_WIDTH +: TAG_WIDTH]     = tag_q[ra*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rf_tagged_mp.sv
// Directed self-checking bench for rf_tagged_mp with default parameters.
module tb_rf_tagged_mp;
    import rf_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned TW = 6;
    localparam int unsigned AW = 5;

    logic              clk;
    logic              rst;
    logic [NR*AW-1:0]  rs_addr;
    logic [NR*W-1:0]   rs_data_out;
    logic [NR-1:0]     rs_busy;
    logic [NR*TW-1:0]  rs_tag;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [TW-1:0]     alloc_tag;
    logic [NW-1:0]     wb_en;
    logic [NW*AW-1:0]  wb_addr;
    logic [NW*TW-1:0]  wb_tag;
    logic [NW*W-1:0]   wb_data;
    logic              flush;

    int n_checks = 0;
    int n_pass   = 0;

    rf_tagged_mp #(
        .RF_WIDTH     (W),
        .RF_DEPTH     (D),
        .NUM_RD_PORTS (NR),
        .NUM_WR_PORTS (NW),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rs_data_out (rs_data_out),
        .rs_busy     (rs_busy),
        .rs_tag      (rs_tag),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .alloc_tag   (alloc_tag),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        alloc_en = 1'b0;
        alloc_addr = '0;
        alloc_tag = '0;
        wb_en = '0;
        wb_addr = '0;
        wb_tag = '0;
        wb_data = '0;
        flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rs_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wb(input int p, input int a, input int t, input logic [W-1:0] d);
        wb_en[p] = 1'b1;
        wb_addr[p*AW +: AW] = AW'(a);
        wb_tag[p*TW +: TW] = TW'(t);
        wb_data[p*W +: W] = d;
    endtask

    task automatic do_alloc(input int a, input int t);
        alloc_en = 1'b1;
        alloc_addr = AW'(a);
        alloc_tag = TW'(t);
        tick();
        clear_ops();
    endtask

    task automatic chk_rd(input string name, input int p, input logic [W-1:0] d, input logic b,
                          input int t);
        check({name, ".data"}, 64'(rs_data_out[p*W +: W]), 64'(d));
        check({name, ".busy"}, 64'(rs_busy[p]), 64'(b));
        check({name, ".tag"}, 64'(rs_tag[p*TW +: TW]), 64'(t));
    endtask

    initial begin
        rst = 1'b0;
        rs_addr = '0;
        clear_ops();
        #1;
        check("reset.data", 64'(rs_data_out), 64'd0);
        check("reset.busy", 64'(rs_busy), 64'd0);
        check("reset.tag", 64'(rs_tag), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Alloc, read status, then same-cycle writeback bypass.
        do_alloc(5, 'h11);
        set_rd(0, 5);
        #1 chk_rd("r5.alloc", 0, 32'h0, 1'b1, 'h11);
        set_wb(0, 5, 'h11, 32'hDEADBEEF);
        #1;
        check("r5.byp.data", 64'(rs_data_out[0 +: W]), 64'hDEADBEEF);
        check("r5.byp.busy", 64'(rs_busy[0]), 64'd0);
        tick();
        clear_ops();
        #1;
        check("r5.state.data", 64'(rs_data_out[0 +: W]), 64'hDEADBEEF);
        check("r5.state.busy", 64'(rs_busy[0]), 64'd0);

        // Stale tag is dropped after re-allocation.
        do_alloc(7, 3);
        do_alloc(7, 9);
        set_wb(0, 7, 3, 32'h55);
        set_rd(1, 7);
        #1 chk_rd("r7.stale.byp", 1, 32'h0, 1'b1, 9);
        tick();
        clear_ops();
        #1 chk_rd("r7.stale", 1, 32'h0, 1'b1, 9);
        set_wb(0, 7, 9, 32'h66);
        tick();
        clear_ops();
        #1 chk_rd("r7.live", 1, 32'h66, 1'b0, 9);

        // Both ports hit the same register: higher port index wins.
        do_alloc(4, 2);
        set_wb(0, 4, 2, 32'hAAAA);
        set_wb(1, 4, 2, 32'hBBBB);
        set_rd(2, 4);
        #1;
        check("r4.byp.data", 64'(rs_data_out[2*W +: W]), 64'hBBBB);
        check("r4.byp.busy", 64'(rs_busy[2]), 64'd0);
        tick();
        clear_ops();
        #1 chk_rd("r4.state", 2, 32'hBBBB, 1'b0, 2);

        // Register 0 is hardwired.
        do_alloc(0, 1);
        for (int p = 0; p < NR; p++) set_rd(p, 0);
        set_wb(0, 0, 1, 32'h1234);
        set_wb(1, 0, 0, 32'h5678);
        #1;
        check("r0.byp.data", 64'(rs_data_out), 64'd0);
        check("r0.byp.busy", 64'(rs_busy), 64'd0);
        tick();
        clear_ops();
        #1;
        check("r0.data", 64'(rs_data_out), 64'd0);
        check("r0.busy", 64'(rs_busy), 64'd0);
        check("r0.tag", 64'(rs_tag), 64'd0);

        // Flush overrides a same-cycle alloc and keeps tags.
        do_alloc(3, 4);
        do_alloc(8, 5);
        set_rd(0, 3);
        set_rd(1, 8);
        set_rd(2, 9);
        #1;
        check("pre_flush.busy", 64'(rs_busy[2:0]), 64'b011);
        alloc_en = 1'b1;
        alloc_addr = AW'(9);
        alloc_tag = TW'(6);
        flush = 1'b1;
        tick();
        clear_ops();
        #1;
        chk_rd("flush.r3", 0, 32'h0, 1'b0, 4);
        chk_rd("flush.r8", 1, 32'h0, 1'b0, 5);
        chk_rd("flush.r9", 2, 32'h0, 1'b0, 0);

        // Effective write in a flush cycle still lands its data.
        do_alloc(10, 7);
        set_wb(1, 10, 7, 32'h77);
        flush = 1'b1;
        set_rd(3, 10);
        tick();
        clear_ops();
        #1 chk_rd("flush_wb.r10", 3, 32'h77, 1'b0, 7);

        // Populate r2/r3, then asynchronous reset between clock edges.
        do_alloc(2, 1);
        do_alloc(3, 2);
        set_wb(0, 2, 1, 32'd446);
        set_wb(1, 3, 2, 32'd331);
        tick();
        clear_ops();
        set_rd(0, 2);
        set_rd(1, 3);
        set_rd(2, 5);
        set_rd(3, 7);
        #1;
        check("pop.r2", 64'(rs_data_out[0 +: W]), 64'd446);
        check("pop.r3", 64'(rs_data_out[W +: W]), 64'd331);
        #1;
        alloc_en = 1'b1;
        alloc_addr = AW'(2);
        alloc_tag = TW'(3);
        rst = 1'b0;
        #1;
        check("async_rst.data", 64'(rs_data_out), 64'd0);
        check("async_rst.busy", 64'(rs_busy), 64'd0);
        check("async_rst.tag", 64'(rs_tag), 64'd0);
        @(negedge clk);
        clear_ops();
        rst = 1'b1;
        tick();
        for (int p = 0; p < NR; p++) begin
            check($sformatf("post_rst.p%0d.data", p), 64'(rs_data_out[p*W +: W]), 64'd0);
            check($sformatf("post_rst.p%0d.busy", p), 64'(rs_busy[p]), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
